axi_slave_write_channel: RTL and testbench
==========================================

AXI_SLAVE_WRITE_CHANNEL -- requirements
Module: axi_slave_write_channel

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AWADDR and mem_write_addr width.
REQ-002 Parameter WRITE_CHANNEL_WIDTH, default 32: WDATA and mem_write_data width.
REQ-003 Parameter WRITE_BURST_LEN, default 8: AWLEN and beat-counter width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: sole clock, all state on rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Ports AWADDR in ADDR_WIDTH, AWVALID in 1, AWLEN in WRITE_BURST_LEN, AWSIZE in 3, AWBURST in 2, AWREADY out 1: write address channel.
REQ-008 Ports WVALID in 1, WDATA in WRITE_CHANNEL_WIDTH, WLAST in 1, WREADY out 1: write data channel.
REQ-009 Ports BREADY in 1, BVALID out 1, BRESP out 1: write response channel; BRESP=1 means OKAY, 0 means error.
REQ-010 Ports mem_write_en out 1, mem_write_addr out ADDR_WIDTH, mem_write_data out WRITE_CHANNEL_WIDTH, mem_write_full in 1: backend write port.
REQ-011 Port done, output, 1: one-cycle pulse when a B handshake completes.

Function
REQ-012 The block SHALL implement states IDLE, DATA and RESP.
REQ-013 IDLE: AWREADY=1, WREADY=0, BVALID=0.
REQ-014 IDLE transition: AWVALID&&AWREADY SHALL latch AWADDR, AWLEN, AWSIZE and AWBURST, clear the beat counter and error flag, and enter DATA next cycle.
REQ-015 DATA: AWREADY=0; WREADY=!mem_write_full; BVALID=0.
REQ-016 A W beat is WVALID&&WREADY.
REQ-017 On a beat, mem_write_en=1 in the same cycle (combinational), with mem_write_addr=current burst address and mem_write_data=WDATA; otherwise mem_write_en=0.
REQ-018 A burst SHALL contain AWLEN+1 beats, beat counter 0..AWLEN; AWLEN=0 is a single beat; AWLEN=255 is 256 beats.
REQ-019 Address update per beat: AWBURST=0 (FIXED) keeps the address constant; AWBURST=1 (INCR) adds (1<<AWSIZE), wrapping modulo 2^ADDR_WIDTH.
REQ-020 AWBURST=2 or 3 SHALL be treated as FIXED and SHALL set the error flag.
REQ-021 Error flag SHALL set on any beat where WLAST != (counter==latched AWLEN).
REQ-022 The burst SHALL end on the beat with counter==AWLEN regardless of WLAST; the next state is RESP.
REQ-023 WVALID while in IDLE or RESP SHALL be ignored: WREADY=0, no memory write.
REQ-024 RESP: BVALID=1, BRESP=!error flag; AWREADY=0, WREADY=0.
REQ-025 BVALID and BRESP SHALL hold stable until BREADY.
REQ-026 On BVALID&&BREADY: done=1 for that cycle; the next state is IDLE.
REQ-027 Minimum turnaround: AW handshake cycle N, first beat possible at N+1, BVALID one cycle after the last beat.
REQ-028 Only one outstanding burst; AW is not accepted outside IDLE.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE; AWREADY=1 once in IDLE; WREADY=0, BVALID=0, BRESP=0, mem_write_en=0, done=0; latched address, length, counter and error flag=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no B response; partially written memory is not rolled back.

Verification
REQ-031 AW{addr=0x100, len=3, size=2, burst=INCR}, 4 beats D0..D3 with WLAST on the 4th -> writes to 0x100, 0x104, 0x108, 0x10C; BVALID with BRESP=1; done pulse.
REQ-032 AW{addr=0x40, len=0, burst=FIXED}, one beat with WLAST -> single write to 0x40; BVALID in the next cycle.
REQ-033 len=3, WLAST asserted on the 2nd beat -> all 4 beats written; BRESP=0.
REQ-034 mem_write_full=1 for 3 cycles mid-burst -> WREADY=0 and no mem_write_en during that window; data order preserved.
REQ-035 BREADY held 0 for 5 cycles in RESP -> BVALID/BRESP stable, AWREADY=0, new AWVALID not accepted until after the B handshake.
REQ-036 rst pulsed after the 2nd beat of a len=7 burst -> IDLE immediately, no BVALID, next AW accepted normally.

Source files
------------

// File: rtl/axi_slave_write_channel.sv
// AXI-style write slave: accepts one burst at a time (AW, then AWLEN+1 W beats,
// then a B response) and forwards every accepted W beat to a simple memory port.
//
// Handshake semantics on every channel: a transfer happens on the rising clk
// edge where VALID && READY are both high; the sender keeps VALID and its payload
// stable until that edge, and READY may depend combinationally on state and on
// mem_write_full but never on the VALID of the same channel.
module axi_slave_write_channel #(
    parameter int ADDR_WIDTH          = 32,
    parameter int WRITE_CHANNEL_WIDTH = 32,
    parameter int WRITE_BURST_LEN     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    input  logic [WRITE_BURST_LEN-1:0]     AWLEN,
    input  logic [2:0]                     AWSIZE,
    input  logic [1:0]                     AWBURST,
    output logic                           AWREADY,
    // write data channel
    input  logic                           WVALID,
    input  logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
    input  logic                           WLAST,
    output logic                           WREADY,
    // write response channel
    input  logic                           BREADY,
    output logic                           BVALID,
    output logic                           BRESP,
    // backend memory write port
    output logic                           mem_write_en,
    output logic [ADDR_WIDTH-1:0]          mem_write_addr,
    output logic [WRITE_CHANNEL_WIDTH-1:0] mem_write_data,
    input  logic                           mem_write_full,
    // status
    output logic                           done,
    output logic [1:0]                     state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;

    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [WRITE_BURST_LEN-1:0] len_q;
    logic [WRITE_BURST_LEN-1:0] cnt_q;
    logic [2:0]                 size_q;
    logic [1:0]                 burst_q;
    logic                       err_q;

    logic                       aw_fire;
    logic                       w_fire;
    logic                       b_fire;
    logic                       last_beat;

    assign aw_fire   = AWVALID && AWREADY;
    assign w_fire    = WVALID && WREADY;
    assign b_fire    = BVALID && BREADY;
    assign last_beat = (cnt_q == len_q);

    // Memory writes are combinational so the beat lands in the same cycle it is accepted.
    assign mem_write_en   = w_fire;
    assign mem_write_addr = addr_q;
    assign mem_write_data = WDATA;
    assign done           = b_fire;
    assign state_dbg      = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and channel ready/valid outputs; the burst ends on beat AWLEN whatever WLAST says.
    always_comb begin
        state_next = state;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        BRESP      = 1'b0;
        case (state)
            IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                WREADY = !mem_write_full;
                if (WVALID && !mem_write_full && last_beat) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                BVALID = 1'b1;
                BRESP  = !err_q;
                if (BREADY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst context: latched on AW, then address/counter/error advance per accepted beat.
    // Reserved burst types (2, 3) behave as FIXED and are flagged as an error up front.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else if (aw_fire) begin
            addr_q  <= AWADDR;
            len_q   <= AWLEN;
            size_q  <= AWSIZE;
            burst_q <= AWBURST;
            cnt_q   <= '0;
            err_q   <= AWBURST[1];
        end else if (w_fire) begin
            if (burst_q == 2'd1) begin
                addr_q <= addr_q + (ADDR_WIDTH'(1) << size_q);
            end
            cnt_q <= cnt_q + WRITE_BURST_LEN'(1);
            if (WLAST != last_beat) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_write_channel.sv
// Bench for axi_slave_write_channel: directed vector table, a few hand-built
// corner sequences (reset mid-burst, W in IDLE) and randomized bursts, with
// expected memory writes held in a scoreboard queue.
module tb_axi_slave_write_channel;

    logic        clk;
    logic        rst;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWREADY;
    logic        WVALID;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WREADY;
    logic        BREADY;
    logic        BVALID;
    logic        BRESP;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_full;
    logic        done;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wlast_idx;
        int          stall_beat;
        int          delay;
        logic        exp_bresp;
    } vec_t;

    vec_t vecs[9];

    axi_slave_write_channel #(
        .ADDR_WIDTH(32),
        .WRITE_CHANNEL_WIDTH(32),
        .WRITE_BURST_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .AWADDR(AWADDR),
        .AWVALID(AWVALID),
        .AWLEN(AWLEN),
        .AWSIZE(AWSIZE),
        .AWBURST(AWBURST),
        .AWREADY(AWREADY),
        .WVALID(WVALID),
        .WDATA(WDATA),
        .WLAST(WLAST),
        .WREADY(WREADY),
        .BREADY(BREADY),
        .BVALID(BVALID),
        .BRESP(BRESP),
        .mem_write_en(mem_write_en),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_write_full(mem_write_full),
        .done(done),
        .state_dbg(state_dbg)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input logic [63:0] act, input logic [63:0] req, input string name);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference address of beat i: INCR steps by 2^size per beat (mod 2^32), everything else stays put.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [2:0] size,
                                              input logic [1:0] burst, input int i);
        if (burst == 2'd1) return base + 32'(i) * (32'd1 << size);
        return base;
    endfunction

    // Scoreboard: every memory write must match the oldest expected beat; full must block WREADY.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_write_full) chk(WREADY, 1'b0, "wready_while_full");
            if (mem_write_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk(1'b1, 1'b0, "unexpected_mem_write");
                end else begin
                    chk(mem_write_addr, exp_addr_q.pop_front(), "mem_write_addr");
                    chk(mem_write_data, exp_data_q.pop_front(), "mem_write_data");
                end
            end
            if (done) chk(BVALID && BREADY, 1'b1, "done_without_b_handshake");
        end
    end

    task automatic send_aw(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        AWVALID = 1'b1; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (AWREADY) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        AWVALID = 1'b0;
        chk(ok, 1'b1, "aw_accept_timeout");
    endtask

    task automatic send_w(input logic [31:0] data, input logic last, input int stall, input bit rnd_full);
        bit ok;
        ok = 1'b0;
        WVALID = 1'b1; WDATA = data; WLAST = last;
        for (int s = 0; s < stall; s++) begin
            mem_write_full = 1'b1;
            @(negedge clk);
            chk(WREADY, 1'b0, "stall_wready");
            chk(mem_write_en, 1'b0, "stall_mem_write_en");
            @(posedge clk); #1;
        end
        for (int t = 0; t < 60; t++) begin
            mem_write_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            chk(AWREADY, 1'b0, "awready_in_data");
            chk(BVALID, 1'b0, "bvalid_in_data");
            if (WREADY) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0; mem_write_full = 1'b0;
        chk(ok, 1'b1, "w_beat_timeout");
    endtask

    // B phase: BVALID must already be up one cycle after the last beat; while BREADY is held
    // low a stray AW and W are offered and must be ignored.
    task automatic get_b(input logic exp_resp, input int delay);
        BREADY = 1'b0;
        for (int d = 0; d < delay; d++) begin
            if (d == 1) begin
                AWVALID = 1'b1; AWADDR = 32'hDEAD_0000; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'd1;
            end
            WVALID = (d == 2);
            @(negedge clk);
            chk(BVALID, 1'b1, "bvalid_hold");
            chk(BRESP, exp_resp, "bresp_hold");
            chk(AWREADY, 1'b0, "awready_in_resp");
            chk(WREADY, 1'b0, "wready_in_resp");
            chk(done, 1'b0, "done_early");
            @(posedge clk); #1;
        end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        @(negedge clk);
        chk(BVALID, 1'b1, "bvalid");
        chk(BRESP, exp_resp, "bresp");
        chk(done, 1'b1, "done_pulse");
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        chk(BVALID, 1'b0, "bvalid_after_b");
        chk(AWREADY, 1'b1, "awready_back_idle");
        chk(done, 1'b0, "done_one_cycle");
    endtask

    // One complete burst; expected B response comes from the table (exp_tab >= 0) or the model.
    task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int wlast_idx, input bit wl_rand,
                             input int stall_beat, input bit rnd_full, input int delay, input int exp_tab);
        bit          err;
        logic        wl;
        logic [31:0] d;
        logic        exp_resp;
        err = (burst >= 2'd2);
        send_aw(a, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if (wl_rand) wl = (i == int'(len)) ^ ($urandom_range(0, 5) == 0);
            else         wl = (i == wlast_idx);
            if (wl != (i == int'(len))) err = 1'b1;
            d = $urandom;
            exp_addr_q.push_back(beat_addr(a, size, burst, i));
            exp_data_q.push_back(d);
            send_w(d, wl, (i == stall_beat) ? 3 : 0, rnd_full);
        end
        chk(exp_addr_q.size(), 0, "writes_outstanding");
        exp_resp = (exp_tab >= 0) ? (exp_tab != 0) : !err;
        get_b(exp_resp, delay);
    endtask

    // Stimulus.
    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        WVALID = 1'b0; WDATA = '0; WLAST = 1'b0; BREADY = 1'b0; mem_write_full = 1'b0;

        vecs[0] = '{32'h0000_0100, 8'd3,   3'd2, 2'd1, 3,   -1, 0, 1'b1}; // basic INCR
        vecs[1] = '{32'h0000_0040, 8'd0,   3'd2, 2'd0, 0,   -1, 0, 1'b1}; // single FIXED beat
        vecs[2] = '{32'h0000_0200, 8'd3,   3'd2, 2'd1, 1,   -1, 5, 1'b0}; // early WLAST, slow BREADY
        vecs[3] = '{32'h0000_0300, 8'd1,   3'd0, 2'd2, 1,   -1, 0, 1'b0}; // reserved burst type 2
        vecs[4] = '{32'hFFFF_FFF8, 8'd3,   3'd2, 2'd1, 3,   -1, 1, 1'b1}; // address wraps past 2^32
        vecs[5] = '{32'h0000_0500, 8'd3,   3'd2, 2'd1, -1,  -1, 0, 1'b0}; // WLAST never asserted
        vecs[6] = '{32'h0000_0600, 8'd2,   3'd3, 2'd3, 2,   -1, 2, 1'b0}; // reserved burst type 3
        vecs[7] = '{32'h0000_1000, 8'd3,   3'd2, 2'd1, 3,   2,  0, 1'b1}; // 3-cycle backpressure
        vecs[8] = '{32'h0000_0000, 8'd255, 3'd0, 2'd1, 255, -1, 0, 1'b1}; // 256-beat burst

        // Reset values while rst is held.
        #3;
        chk(AWREADY, 1'b1, "rst_awready");
        chk(WREADY, 1'b0, "rst_wready");
        chk(BVALID, 1'b0, "rst_bvalid");
        chk(BRESP, 1'b0, "rst_bresp");
        chk(mem_write_en, 1'b0, "rst_mem_write_en");
        chk(done, 1'b0, "rst_done");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // W offered in IDLE is ignored.
        WVALID = 1'b1; WDATA = 32'hBAD0_BAD0; WLAST = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk(WREADY, 1'b0, "wready_in_idle");
            chk(mem_write_en, 1'b0, "write_in_idle");
            @(posedge clk); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;

        // Directed table.
        for (int v = 0; v < 9; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].wlast_idx,
                      1'b0, vecs[v].stall_beat, 1'b0, vecs[v].delay, int'(vecs[v].exp_bresp));
        end

        // Reset after the 2nd beat of an 8-beat burst: abandon it, then a fresh burst works.
        send_aw(32'h0000_0800, 8'd7, 3'd2, 2'd1);
        for (int i = 0; i < 2; i++) begin
            exp_addr_q.push_back(beat_addr(32'h0000_0800, 3'd2, 2'd1, i));
            exp_data_q.push_back(32'hC0DE_0000 + 32'(i));
            send_w(32'hC0DE_0000 + 32'(i), 1'b0, 0, 1'b0);
        end
        WVALID = 1'b1; WDATA = 32'h1234_5678;
        rst = 1'b1;
        #1;
        chk(AWREADY, 1'b1, "midrst_awready");
        chk(WREADY, 1'b0, "midrst_wready");
        chk(BVALID, 1'b0, "midrst_bvalid");
        chk(mem_write_en, 1'b0, "midrst_mem_write_en");
        chk(done, 1'b0, "midrst_done");
        chk(exp_addr_q.size(), 0, "midrst_writes_before");
        @(posedge clk); #1;
        WVALID = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(BVALID, 1'b0, "no_b_after_reset");
            chk(AWREADY, 1'b1, "idle_after_reset");
            @(posedge clk); #1;
        end
        run_burst(32'h0000_0900, 8'd1, 3'd2, 2'd1, 1, 1'b0, -1, 1'b0, 0, 1);

        // Randomized bursts against the model.
        for (int r = 0; r < 25; r++) begin
            run_burst($urandom, 8'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1)),
                      0, ($urandom_range(0, 2) == 0), -1, 1'b1, $urandom_range(0, 3), -1);
        end

        chk(exp_addr_q.size(), 0, "final_queue_empty");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
